// File: rtl/thread_wb_unit.sv
// Writeback/commit stage: ALU and LSU results share one register-file write port, plus the per-thread PC table.
// Optional WB_PERF_CNT_EN adds per-thread retire counters and an LSU-blocked cycle counter.
module thread_wb_unit #(
  parameter int XLEN           = 32,
  parameter int ADDR_LEN       = 32,
  parameter int THREADS        = 4,
  parameter int LSU_FIFO_DEPTH = 2,
  parameter logic [ADDR_LEN-3:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alu_valid,
  input  logic                alu_rd_en,
  input  logic [4:0]          alu_rd_addr,
  input  logic [XLEN-1:0]     alu_rd_data,
  input  logic [ADDR_LEN-3:0] alu_new_pc,
  input  logic [1:0]          alu_thread,
  input  logic                lsu_valid,
  output logic                lsu_ready,
  input  logic [4:0]          lsu_rd_addr,
  input  logic [XLEN-1:0]     lsu_rd_data,
  input  logic [1:0]          lsu_thread,
  output logic                rf_we,
  output logic [1:0]          rf_thread,
  output logic [4:0]          rf_waddr,
  output logic [XLEN-1:0]     rf_wdata,
  input  logic [1:0]          fetch_thread,
  output logic [ADDR_LEN-3:0] fetch_pc,
  output logic                retire_valid,
  output logic [1:0]          retire_thread
`ifdef WB_PERF_CNT_EN
  ,
  input  logic [1:0]          perf_sel,
  output logic [31:0]         perf_retire_cnt,
  output logic [31:0]         perf_stall_cnt
`endif
);

  localparam int PTR_W = $clog2(LSU_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [1:0]      thread;
    logic [4:0]      addr;
    logic [XLEN-1:0] data;
  } lsu_entry_t;

  lsu_entry_t          fifo_mem [LSU_FIFO_DEPTH];
  lsu_entry_t          head;
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    count;
  logic [ADDR_LEN-3:0] pc_table [THREADS];
  logic                alu_claim, fifo_empty, fifo_full, push, pop;

  assign alu_claim  = alu_valid && alu_rd_en && (alu_rd_addr != 5'd0);
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_W'(LSU_FIFO_DEPTH));
  assign lsu_ready  = rst && !fifo_full;
  assign push       = lsu_valid && lsu_ready;
  // Any ALU result owns the single retire slot, so the LSU head waits even on ALU non-writes.
  assign pop        = !fifo_empty && !alu_valid;
  assign head       = fifo_mem[rd_ptr];
  assign fetch_pc   = pc_table[fetch_thread];

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= '{thread: lsu_thread, addr: lsu_rd_addr, data: lsu_rd_data};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      rf_we         <= 1'b0;
      rf_thread     <= 2'd0;
      rf_waddr      <= 5'd0;
      rf_wdata      <= '0;
      retire_valid  <= 1'b0;
      retire_thread <= 2'd0;
      for (int i = 0; i < THREADS; i++) pc_table[i] <= RESET_PC;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (alu_valid) pc_table[alu_thread] <= alu_new_pc;

      if (alu_valid) begin
        rf_we         <= alu_claim;
        rf_thread     <= alu_thread;
        rf_waddr      <= alu_rd_addr;
        rf_wdata      <= alu_rd_data;
        retire_valid  <= 1'b1;
        retire_thread <= alu_thread;
      end else if (pop) begin
        rf_we         <= (head.addr != 5'd0);
        rf_thread     <= head.thread;
        rf_waddr      <= head.addr;
        rf_wdata      <= head.data;
        retire_valid  <= 1'b1;
        retire_thread <= head.thread;
      end else begin
        rf_we         <= 1'b0;
        retire_valid  <= 1'b0;
      end
    end
  end

`ifdef WB_PERF_CNT_EN
  logic [31:0] retire_cnt [THREADS];
  logic [31:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt <= '0;
      for (int i = 0; i < THREADS; i++) retire_cnt[i] <= '0;
    end else begin
      if (alu_valid)  retire_cnt[alu_thread]  <= retire_cnt[alu_thread] + 32'd1;
      else if (pop)   retire_cnt[head.thread] <= retire_cnt[head.thread] + 32'd1;
      if (!fifo_empty && alu_valid) stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign perf_retire_cnt = retire_cnt[perf_sel];
  assign perf_stall_cnt  = stall_cnt;
`else
  // Counters compiled out; datapath behaviour is unchanged.
`endif

endmodule

// File: tb/tb_thread_wb_unit.sv
// Scoreboard bench for thread_wb_unit: directed test-plan cases followed by randomized ALU/LSU traffic.
module tb_thread_wb_unit;
  localparam int DEPTH = 2;

  logic        clk, rst;
  logic        alu_valid, alu_rd_en;
  logic [4:0]  alu_rd_addr;
  logic [31:0] alu_rd_data;
  logic [29:0] alu_new_pc;
  logic [1:0]  alu_thread;
  logic        lsu_valid, lsu_ready;
  logic [4:0]  lsu_rd_addr;
  logic [31:0] lsu_rd_data;
  logic [1:0]  lsu_thread;
  logic        rf_we;
  logic [1:0]  rf_thread;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [1:0]  fetch_thread;
  logic [29:0] fetch_pc;
  logic        retire_valid;
  logic [1:0]  retire_thread;
`ifdef WB_PERF_CNT_EN
  logic [1:0]  perf_sel = 2'd0;
  logic [31:0] perf_retire_cnt, perf_stall_cnt;
`endif

  thread_wb_unit dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd_en(alu_rd_en), .alu_rd_addr(alu_rd_addr),
    .alu_rd_data(alu_rd_data), .alu_new_pc(alu_new_pc), .alu_thread(alu_thread),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd_addr(lsu_rd_addr),
    .lsu_rd_data(lsu_rd_data), .lsu_thread(lsu_thread),
    .rf_we(rf_we), .rf_thread(rf_thread), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .fetch_thread(fetch_thread), .fetch_pc(fetch_pc),
    .retire_valid(retire_valid), .retire_thread(retire_thread)
`ifdef WB_PERF_CNT_EN
    , .perf_sel(perf_sel), .perf_retire_cnt(perf_retire_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  typedef struct {
    int          cyc;
    logic        we;
    logic [1:0]  th;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic [1:0]  th;
    logic [4:0]  addr;
    logic [31:0] data;
  } load_t;

  exp_t  exp_q[$];
  load_t offers[$];
  load_t model_fifo[$];
  logic [29:0] model_pc [4];
  bit    pc_known = 0;
  int    cyc = 0;
  int    n_checks = 0;
  int    n_fail = 0;

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Monitor: every cycle, expire overdue predictions, then match whatever the DUT presents.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      chk("missing_result", 64'(e.cyc), 64'(cyc));
    end
    if (rf_we === 1'b1 || retire_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", {rf_we, retire_valid}, 2'b00);
      end else begin
        e = exp_q.pop_front();
        chk("result_cycle", 64'(cyc), 64'(e.cyc));
        chk("retire_valid", retire_valid, 1'b1);
        chk("retire_thread", retire_thread, e.th);
        chk("rf_we", rf_we, e.we);
        if (e.we) begin
          chk("rf_thread", rf_thread, e.th);
          chk("rf_waddr", rf_waddr, e.addr);
          chk("rf_wdata", rf_wdata, e.data);
        end
      end
    end
  end

  // One cycle of stimulus plus the reference model's view of what that cycle must produce.
  task automatic drive(input logic r, input logic av, input logic ren, input logic [4:0] ra,
                       input logic [31:0] rd, input logic [29:0] npc, input logic [1:0] ath,
                       input logic [1:0] fth);
    bit m_ready;
    load_t h;
    @(negedge clk);
    rst = r; alu_valid = av; alu_rd_en = ren; alu_rd_addr = ra; alu_rd_data = rd;
    alu_new_pc = npc; alu_thread = ath; fetch_thread = fth;
    lsu_valid = (offers.size() > 0);
    if (offers.size() > 0) begin
      lsu_thread = offers[0].th; lsu_rd_addr = offers[0].addr; lsu_rd_data = offers[0].data;
    end
    #1;
    m_ready = r && (model_fifo.size() < DEPTH);
    chk("lsu_ready", lsu_ready, m_ready);
    if (pc_known && r) chk("fetch_pc", fetch_pc, model_pc[fth]);
    if (!r) begin
      model_fifo.delete();
      offers.delete();
      for (int i = 0; i < 4; i++) model_pc[i] = 30'd0;
      pc_known = 1;
    end else begin
      if (av) exp_q.push_back('{cyc + 1, ren && ra != 5'd0, ath, ra, rd});
      else if (model_fifo.size() > 0) begin
        h = model_fifo.pop_front();
        exp_q.push_back('{cyc + 1, h.addr != 5'd0, h.th, h.addr, h.data});
      end
      if (lsu_valid && m_ready) model_fifo.push_back(offers.pop_front());
      if (av) model_pc[ath] = npc;
    end
  endtask

  task automatic idle(input logic [1:0] fth);
    drive(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 30'd0, 2'd0, fth);
  endtask

  task automatic offer(input logic [1:0] th, input logic [4:0] a, input logic [31:0] d);
    offers.push_back('{th, a, d});
  endtask

  initial begin
    rst = 0; alu_valid = 0; alu_rd_en = 0; alu_rd_addr = 0; alu_rd_data = 0;
    alu_new_pc = 0; alu_thread = 0; lsu_valid = 0; lsu_rd_addr = 0; lsu_rd_data = 0;
    lsu_thread = 0; fetch_thread = 0;

    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 30'd0, 2'd0, 2'd0);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 30'd0, 2'd0, 2'd0);
    for (int t = 0; t < 4; t++) idle(2'(t));
    chk("rf_we_after_reset", rf_we, 1'b0);

    // ALU write on thread 2, then PC visible the next cycle
    drive(1'b1, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 30'h40, 2'd2, 2'd2);
    idle(2'd2);
    // ALU non-write (rd=0) still retires and updates the PC
    drive(1'b1, 1'b1, 1'b1, 5'd0, 32'h1234, 30'h77, 2'd3, 2'd3);
    idle(2'd3);
    drive(1'b1, 1'b1, 1'b0, 5'd9, 32'h55, 30'h12, 2'd0, 2'd0);
    idle(2'd0);

    // LSU with idle ALU: two-cycle latency
    offer(2'd1, 5'd7, 32'hA5A5A5A5);
    for (int i = 0; i < 3; i++) idle(2'd1);
    offer(2'd2, 5'd0, 32'hFFFF0000);
    for (int i = 0; i < 3; i++) idle(2'd2);

    // ALU writes 4 cycles while 3 loads are offered: FIFO fills, drains in order afterwards
    offer(2'd0, 5'd1, 32'h11111111);
    offer(2'd1, 5'd2, 32'h22222222);
    offer(2'd3, 5'd3, 32'h33333333);
    for (int i = 0; i < 4; i++)
      drive(1'b1, 1'b1, 1'b1, 5'(10 + i), 32'hC0DE0000 + 32'(i), 30'(100 + i), 2'(i), 2'(i));
    for (int i = 0; i < 6; i++) idle(2'(i));

    // Reset with two loads buffered: they must be discarded and PCs restored
    offer(2'd1, 5'd20, 32'hBAD00001);
    offer(2'd2, 5'd21, 32'hBAD00002);
    drive(1'b1, 1'b1, 1'b1, 5'd4, 32'h4444, 30'h300, 2'd1, 2'd1);
    drive(1'b1, 1'b1, 1'b1, 5'd6, 32'h6666, 30'h301, 2'd2, 2'd2);
    drive(1'b0, 1'b1, 1'b1, 5'd8, 32'h8888, 30'h302, 2'd3, 2'd3);
    for (int t = 0; t < 4; t++) idle(2'(t));
    for (int i = 0; i < 4; i++) idle(2'd0);

    // Randomized traffic with varying ALU load so the FIFO both fills and drains
    for (int i = 0; i < 400; i++) begin
      int alu_pct;
      alu_pct = ((i / 50) % 2 == 0) ? 85 : 30;
      if (offers.size() == 0 && $urandom_range(0, 99) < 60)
        offer(2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
              $urandom);
      drive(($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1,
            $urandom_range(0, 99) < alu_pct,
            $urandom_range(0, 9) != 0,
            ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
            $urandom, 30'($urandom), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    end
    for (int i = 0; i < 8; i++) idle(2'(i));
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
